block_mem_responder: RTL and testbench

//  Memory-side responder for the cache line interface. Accepts one block read
//  (line fill) or block write (writeback) request from the cache controller.

---
 rtl/block_mem_responder_pkg.sv | 27 ++
 rtl/block_mem_responder_if.sv | 36 +++
 rtl/block_word_insert.sv | 17 +
 rtl/block_mem_responder.sv | 126 ++++++++++++
 tb/tb_block_mem_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared widths, FSM state encoding and the 4:1 word select for the block memory responder.
// Optional feature macro used by the top level: CRITICAL_WORD_FIRST_EN.
package block_mem_responder_pkg;

    localparam int ADDR_W          = 32;
    localparam int WORD_SIZE_BIT   = 32;
    localparam int DATA_BLOCK      = 128;
    localparam int WORDS_PER_BLOCK = DATA_BLOCK / WORD_SIZE_BIT;
    localparam int BLOCK_OFF_BITS  = 4;
    localparam int BEAT_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Word select used by the cache datapath; the insert sub-module is its inverse.
    function automatic logic [WORD_SIZE_BIT-1:0] word_sel(
        input logic [DATA_BLOCK-1:0] blk,
        input logic [BEAT_W-1:0]     lane
    );
        return blk[lane*WORD_SIZE_BIT +: WORD_SIZE_BIT];
    endfunction

endpackage

// File: rtl/block_mem_responder_if.sv
// Cache-side request/response and memory-side word port of the block memory responder.
// slave = responder view, master = cache controller / main memory view.
interface block_mem_responder_if;
    import block_mem_responder_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_BLOCK-1:0]    req_wdata;

    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_we;
    logic [DATA_BLOCK-1:0]    resp_rdata;

    logic                     mem_re;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [WORD_SIZE_BIT-1:0] mem_wdata;
    logic [WORD_SIZE_BIT-1:0] mem_rdata;
    logic                     mem_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_we, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_we, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/block_word_insert.sv
// Combinational insert of one memory word into lane i_lane of a cache block;
// all other lanes pass through unchanged.
module block_word_insert
    import block_mem_responder_pkg::*;
(
    input  logic [DATA_BLOCK-1:0]    i_block,
    input  logic [WORD_SIZE_BIT-1:0] i_word,
    input  logic [BEAT_W-1:0]        i_lane,
    output logic [DATA_BLOCK-1:0]    o_block
);

    always_comb begin
        o_block = i_block;
        o_block[i_lane*WORD_SIZE_BIT +: WORD_SIZE_BIT] = i_word;
    end

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder: splits/assembles a cache line into word beats on main memory.
// Define CRITICAL_WORD_FIRST_EN to start read beats at the requested word offset.
module block_mem_responder
    import block_mem_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    block_mem_responder_if.slave bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [BEAT_W-1:0]        r_beat;
    logic [BEAT_W-1:0]        r_cnt;
    logic                     r_we;
    logic [ADDR_W-1:0]        r_base;
    logic [DATA_BLOCK-1:0]    r_wdata;
    logic [DATA_BLOCK-1:0]    r_block;

    logic [DATA_BLOCK-1:0]    w_block_ins;
    logic [BEAT_W-1:0]        w_first_beat;
    logic                     w_accept;
    logic                     w_beat_done;
    logic                     w_last;
    logic                     w_req_ready;
    logic                     w_mem_re;
    logic                     w_mem_we;
    logic                     w_resp_valid;

    // Writes always stream lanes 0..3; reads may begin at the critical word.
`ifdef CRITICAL_WORD_FIRST_EN
    assign w_first_beat = bus.req_we ? '0 : bus.req_addr[BLOCK_OFF_BITS-1:2];
`else
    assign w_first_beat = '0;
`endif

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_beat_done = ((r_state == ST_RD) || (r_state == ST_WR)) && bus.mem_ack;
    assign w_last      = w_beat_done && (r_cnt == BEAT_W'(WORDS_PER_BLOCK - 1));

    block_word_insert u_insert (
        .i_block (r_block),
        .i_word  (bus.mem_rdata),
        .i_lane  (r_beat),
        .o_block (w_block_ins)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_nxt = bus.req_we ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                w_mem_re = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_WR: begin
                w_mem_we = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Block register is cleared on every accept so a write response carries zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat  <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_block <= '0;
        end else if (w_accept) begin
            r_beat  <= w_first_beat;
            r_cnt   <= '0;
            r_we    <= bus.req_we;
            r_base  <= {bus.req_addr[ADDR_W-1:BLOCK_OFF_BITS], {BLOCK_OFF_BITS{1'b0}}};
            r_wdata <= bus.req_wdata;
            r_block <= '0;
        end else if (w_beat_done) begin
            r_beat <= r_beat + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_state == ST_RD) begin
                r_block <= w_block_ins;
            end
        end
    end

    // req_ready is also gated by reset so it drops the instant reset rises.
    assign bus.req_ready  = w_req_ready && !reset;
    assign bus.mem_re     = w_mem_re;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = r_base + {{(ADDR_W-BLOCK_OFF_BITS){1'b0}}, r_beat, 2'b00};
    assign bus.mem_wdata  = w_mem_we ? word_sel(r_wdata, r_beat) : '0;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_we    = r_we;
    assign bus.resp_rdata = r_block;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder with a wait-state memory model and beat log.
module tb_block_mem_responder;
    import block_mem_responder_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int          mem_wait;
    logic [31:0] mem_tag;
    logic        spur_ack;
    int          wcnt;

    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    int          log_hold [0:63];
    int          lidx;

    block_mem_responder_if bus();

    block_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_ack   = ((bus.mem_re || bus.mem_we) && (wcnt == mem_wait)) || spur_ack;
    assign bus.mem_rdata = bus.mem_ack ? (mem_tag + {30'd0, bus.mem_addr[3:2]}) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if ((bus.mem_re || bus.mem_we) && bus.mem_ack) begin
            log_addr[lidx % 64] <= bus.mem_addr;
            log_data[lidx % 64] <= bus.mem_wdata;
            log_hold[lidx % 64] <= wcnt + 1;
            lidx                <= lidx + 1;
            wcnt                <= 0;
        end else if (bus.mem_re || bus.mem_we) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    initial begin
        lidx = 0;
        wcnt = 0;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        while (!bus.resp_valid && n < max) begin
            tick();
            n++;
        end
        check("resp_timeout", 128'(bus.resp_valid), 128'd1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [127:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("post_resp_valid", 128'(bus.resp_valid), 128'd0);
        check("post_req_ready", 128'(bus.req_ready), 128'd1);
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] exp_order [0:3];
        checks = 0;
        errors = 0;
        reset = 1'b1;
        mem_wait = 0;
        mem_tag = 32'hA0;
        spur_ack = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 128'(bus.req_ready), 128'd0);
        check("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
        check("rst_strobes", 128'({bus.mem_re, bus.mem_we}), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_rdata", bus.resp_rdata, 128'd0);
        reset = 1'b0;
        tick();
        check("idle_req_ready", 128'(bus.req_ready), 128'd1);

        // Spurious ack in IDLE must be ignored.
        spur_ack = 1'b1;
        tick();
        tick();
        spur_ack = 1'b0;
        check("spur_rdata", bus.resp_rdata, 128'd0);
        check("spur_req_ready", 128'(bus.req_ready), 128'd1);
        check("spur_strobes", 128'({bus.mem_re, bus.mem_we, bus.resp_valid}), 128'd0);

        // Test 1: zero-wait read at 0x1000.
        base = lidx;
        issue(1'b0, 32'h0000_1000, '0);
        check("t1_mem_re", 128'(bus.mem_re), 128'd1);
        wait_resp(20, n);
        check("t1_latency", 128'(n), 128'd4);
        check("t1_beats", 128'(lidx - base), 128'd4);
        for (int k = 0; k < 4; k++) begin
            check("t1_addr", 128'(log_addr[(base + k) % 64]), 128'(32'h1000 + 4 * k));
        end
        check("t1_rdata", bus.resp_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
        check("t1_resp_we", 128'(bus.resp_we), 128'd0);
        check("t1_req_ready", 128'(bus.req_ready), 128'd0);
        handshake();

        // Test 2: write at 0x2004 with two wait states per beat.
        mem_wait = 2;
        base = lidx;
        issue(1'b1, 32'h0000_2004, 128'h4444DDDD_3333CCCC_2222BBBB_1111AAAA);
        wait_resp(60, n);
        check("t2_beats", 128'(lidx - base), 128'd4);
        check("t2_addr0", 128'(log_addr[(base + 0) % 64]), 128'h2000);
        check("t2_addr3", 128'(log_addr[(base + 3) % 64]), 128'h200C);
        check("t2_data0", 128'(log_data[(base + 0) % 64]), 128'h1111AAAA);
        check("t2_data1", 128'(log_data[(base + 1) % 64]), 128'h2222BBBB);
        check("t2_data2", 128'(log_data[(base + 2) % 64]), 128'h3333CCCC);
        check("t2_data3", 128'(log_data[(base + 3) % 64]), 128'h4444DDDD);
        for (int k = 0; k < 4; k++) begin
            check("t2_hold", 128'(log_hold[(base + k) % 64]), 128'd3);
        end
        check("t2_resp_we", 128'(bus.resp_we), 128'd1);
        check("t2_rdata", bus.resp_rdata, 128'd0);
        handshake();

        // Test 3: read at 0x3008; order depends on critical-word-first build.
        mem_wait = 0;
        mem_tag = 32'hC0;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_order[0] = 32'h3008; exp_order[1] = 32'h300C;
        exp_order[2] = 32'h3000; exp_order[3] = 32'h3004;
`else
        exp_order[0] = 32'h3000; exp_order[1] = 32'h3004;
        exp_order[2] = 32'h3008; exp_order[3] = 32'h300C;
`endif
        base = lidx;
        issue(1'b0, 32'h0000_3008, '0);
        wait_resp(20, n);
        for (int k = 0; k < 4; k++) begin
            check("t3_order", 128'(log_addr[(base + k) % 64]), 128'(exp_order[k]));
        end
        check("t3_rdata", bus.resp_rdata, 128'h000000C3_000000C2_000000C1_000000C0);
        handshake();

        // Test 4: response back-pressure with a pending request.
        mem_tag = 32'hD0;
        issue(1'b0, 32'h0000_4000, '0);
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0000_5000;
        wait_resp(20, n);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_hold_valid", 128'(bus.resp_valid), 128'd1);
            check("t4_hold_rdata", bus.resp_rdata, 128'h000000D3_000000D2_000000D1_000000D0);
            check("t4_req_ready", 128'(bus.req_ready), 128'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("t4_idle_ready", 128'(bus.req_ready), 128'd1);
        check("t4_idle_re", 128'(bus.mem_re), 128'd0);
        tick();
        bus.req_valid = 1'b0;
        check("t4_next_re", 128'(bus.mem_re), 128'd1);
        check("t4_next_addr", 128'(bus.mem_addr), 128'h5000);
        wait_resp(20, n);
        handshake();

        // Test 5: reset after the second read ack, then a fresh read.
        mem_tag = 32'hE0;
        issue(1'b0, 32'h0000_6000, '0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t5_mem_re", 128'(bus.mem_re), 128'd0);
        check("t5_resp_valid", 128'(bus.resp_valid), 128'd0);
        check("t5_req_ready", 128'(bus.req_ready), 128'd0);
        check("t5_rdata", bus.resp_rdata, 128'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_ready_again", 128'(bus.req_ready), 128'd1);
        mem_tag = 32'hF0;
        base = lidx;
        issue(1'b0, 32'h0000_6000, '0);
        wait_resp(20, n);
        check("t5_beats", 128'(lidx - base), 128'd4);
        check("t5_fresh", bus.resp_rdata, 128'h000000F3_000000F2_000000F1_000000F0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
